// File: rtl/score_overlay_if.sv
// Bundle between the VGA timing/game logic (master) and the score overlay
// renderer (slave): pixel position, frame/game event pulses and the overlay pixel.
interface score_overlay_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       display_en;
    logic       frame_start;
    logic       hit_event;
    logic       miss_event;
    logic       score_clear;
    logic       overlay_active;
    logic [3:0] overlay_r;
    logic [3:0] overlay_g;
    logic [3:0] overlay_b;

    modport master (
        output hcount, vcount, display_en, frame_start,
               hit_event, miss_event, score_clear,
        input  overlay_active, overlay_r, overlay_g, overlay_b
    );

    modport slave (
        input  hcount, vcount, display_en, frame_start,
               hit_event, miss_event, score_clear,
        output overlay_active, overlay_r, overlay_g, overlay_b
    );
endinterface

// File: rtl/score_overlay.sv
// Pong hit/miss score keeper and 7-segment overlay renderer. Scores change only
// at frame start so a frame never shows two different values.
module score_overlay #(
    parameter int HIT_X        = 256,
    parameter int MISS_X       = 352,
    parameter int SCORE_Y      = 16,
    parameter int DIGIT_PITCH  = 24,
    parameter int FLASH_FRAMES = 32
) (
    input  logic           clk_25mhz,
    input  logic           reset,
    score_overlay_if.slave ovl
);
    localparam int CELL_W = 16;
    localparam int CELL_H = 32;
    localparam int CNT_W  = $clog2(FLASH_FRAMES);

    localparam logic [CNT_W-1:0] FLASH_LOAD   = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [9:0]       HIT_TENS_X   = 10'(HIT_X);
    localparam logic [9:0]       HIT_UNITS_X  = 10'(HIT_X + DIGIT_PITCH);
    localparam logic [9:0]       MISS_TENS_X  = 10'(MISS_X);
    localparam logic [9:0]       MISS_UNITS_X = 10'(MISS_X + DIGIT_PITCH);
    localparam logic [9:0]       TOP_Y        = 10'(SCORE_Y);

    typedef enum logic {
        IDLE,
        FLASH
    } flash_state_t;

    logic [3:0]       hit_tens;
    logic [3:0]       hit_units;
    logic [3:0]       miss_tens;
    logic [3:0]       miss_units;
    logic             hit_pend;
    logic             miss_pend;
    flash_state_t     flash_state;
    logic [CNT_W-1:0] flash_cnt;

    logic             hit_inc;
    logic             miss_inc;
    logic             miss_hidden;
    logic             row_in;
    logic [4:0]       ly;
    logic             hit_pix;
    logic             miss_pix;

    logic             pix_active;
    logic [3:0]       pix_r;
    logic [3:0]       pix_g;
    logic [3:0]       pix_b;

    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units);
        logic [7:0] result;
        if (units != 4'd9) begin
            result = {tens, units + 4'd1};
        end else if (tens != 4'd9) begin
            result = {tens + 4'd1, 4'd0};
        end else begin
            result = 8'h00;
        end
        return result;
    endfunction

    // Segment order is {a,b,c,d,e,f,g}; 10-15 never occur so they render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    function automatic logic glyph_lit(input logic [3:0] digit,
                                       input logic [3:0] lx,
                                       input logic [4:0] gy);
        logic [6:0] seg;
        logic       left;
        logic       right;
        logic       upper;
        seg   = seg_decode(digit);
        left  = (lx <= 4'd3);
        right = (lx >= 4'd12);
        upper = (gy <= 5'd15);
        return (seg[6] && (gy <= 5'd3))
            || (seg[5] && right && upper)
            || (seg[4] && right && !upper)
            || (seg[3] && (gy >= 5'd28))
            || (seg[2] && left && !upper)
            || (seg[1] && left && upper)
            || (seg[0] && (gy >= 5'd14) && (gy <= 5'd17));
    endfunction

    // Widened unsigned compare so pixels left of a cell never alias into it.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] start, input int len);
        return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < ({1'b0, start} + 11'(len)));
    endfunction

    assign hit_inc     = hit_pend | ovl.hit_event;
    assign miss_inc    = miss_pend | ovl.miss_event;
    assign miss_hidden = (flash_state == FLASH) && flash_cnt[2];

    // Score digits, pending events and the miss-blink FSM.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            hit_tens    <= 4'd0;
            hit_units   <= 4'd0;
            miss_tens   <= 4'd0;
            miss_units  <= 4'd0;
            hit_pend    <= 1'b0;
            miss_pend   <= 1'b0;
            flash_state <= IDLE;
            flash_cnt   <= '0;
        end else if (ovl.score_clear) begin
            hit_tens    <= 4'd0;
            hit_units   <= 4'd0;
            miss_tens   <= 4'd0;
            miss_units  <= 4'd0;
            hit_pend    <= 1'b0;
            miss_pend   <= 1'b0;
            flash_state <= IDLE;
            flash_cnt   <= '0;
        end else if (ovl.frame_start) begin
            hit_pend  <= 1'b0;
            miss_pend <= 1'b0;
            if (hit_inc) begin
                {hit_tens, hit_units} <= bcd_inc(hit_tens, hit_units);
            end
            if (miss_inc) begin
                {miss_tens, miss_units} <= bcd_inc(miss_tens, miss_units);
                flash_state             <= FLASH;
                flash_cnt               <= FLASH_LOAD;
            end else if (flash_state == FLASH) begin
                if (flash_cnt == '0) begin
                    flash_state <= IDLE;
                end else begin
                    flash_cnt <= flash_cnt - CNT_W'(1);
                end
            end
        end else begin
            if (ovl.hit_event) begin
                hit_pend <= 1'b1;
            end
            if (ovl.miss_event) begin
                miss_pend <= 1'b1;
            end
        end
    end

    assign row_in = in_span(ovl.vcount, TOP_Y, CELL_H);
    assign ly     = 5'(ovl.vcount - TOP_Y);

    assign hit_pix = row_in && (
          (in_span(ovl.hcount, HIT_TENS_X, CELL_W)
              && glyph_lit(hit_tens, 4'(ovl.hcount - HIT_TENS_X), ly))
       || (in_span(ovl.hcount, HIT_UNITS_X, CELL_W)
              && glyph_lit(hit_units, 4'(ovl.hcount - HIT_UNITS_X), ly)));

    assign miss_pix = row_in && !miss_hidden && (
          (in_span(ovl.hcount, MISS_TENS_X, CELL_W)
              && glyph_lit(miss_tens, 4'(ovl.hcount - MISS_TENS_X), ly))
       || (in_span(ovl.hcount, MISS_UNITS_X, CELL_W)
              && glyph_lit(miss_units, 4'(ovl.hcount - MISS_UNITS_X), ly)));

    // One register stage keeps the overlay aligned with the sprite renderer.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            pix_active <= 1'b0;
            pix_r      <= 4'h0;
            pix_g      <= 4'h0;
            pix_b      <= 4'h0;
        end else begin
            pix_active <= ovl.display_en && (hit_pix || miss_pix);
            pix_r      <= (ovl.display_en && (hit_pix || miss_pix)) ? 4'hF : 4'h0;
            pix_g      <= (ovl.display_en && (hit_pix || miss_pix)) ? 4'hF : 4'h0;
            pix_b      <= (ovl.display_en && hit_pix) ? 4'hF : 4'h0;
        end
    end

    assign ovl.overlay_active = pix_active;
    assign ovl.overlay_r      = pix_r;
    assign ovl.overlay_g      = pix_g;
    assign ovl.overlay_b      = pix_b;
endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: probes one pixel per segment of each digit
// against a small score/flash model driven alongside the stimulus.
`timescale 1ns/1ps
module tb_score_overlay;
    localparam int HIT_X        = 256;
    localparam int MISS_X       = 352;
    localparam int SCORE_Y      = 16;
    localparam int DIGIT_PITCH  = 24;
    localparam int FLASH_FRAMES = 32;

    localparam logic [12:0] OFF    = 13'h0000;
    localparam logic [12:0] WHITE  = {1'b1, 12'hFFF};
    localparam logic [12:0] YELLOW = {1'b1, 12'hFF0};

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam int SEG_LX [7] = '{4, 13, 13, 4, 1, 1, 8};
    localparam int SEG_LY [7] = '{1, 5, 20, 30, 20, 5, 15};

    logic clk_25mhz = 1'b0;
    logic reset;

    score_overlay_if ovl();

    score_overlay #(
        .HIT_X(HIT_X), .MISS_X(MISS_X), .SCORE_Y(SCORE_Y),
        .DIGIT_PITCH(DIGIT_PITCH), .FLASH_FRAMES(FLASH_FRAMES)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .reset(reset),
        .ovl(ovl)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int checks   = 0;
    int failures = 0;

    int exp_hit;
    int exp_miss;
    bit hit_pend_m;
    bit miss_pend_m;
    bit flash_on;
    int flash_cnt_m;

    function automatic logic [12:0] observed();
        return {ovl.overlay_active, ovl.overlay_r, ovl.overlay_g, ovl.overlay_b};
    endfunction

    function automatic bit miss_shown();
        return !(flash_on && ((flash_cnt_m & 4) != 0));
    endfunction

    task automatic model_reset();
        exp_hit     = 0;
        exp_miss    = 0;
        hit_pend_m  = 0;
        miss_pend_m = 0;
        flash_on    = 0;
        flash_cnt_m = 0;
    endtask

    task automatic check_output(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model, and land 1 ns after the edge.
    task automatic apply_stimulus(input int h, input int v, input bit de,
                                  input bit fs, input bit hit, input bit miss, input bit clr);
        bit hi;
        bit mi;
        ovl.hcount      = 10'(h);
        ovl.vcount      = 10'(v);
        ovl.display_en  = de;
        ovl.frame_start = fs;
        ovl.hit_event   = hit;
        ovl.miss_event  = miss;
        ovl.score_clear = clr;
        if (clr) begin
            model_reset();
        end else if (fs) begin
            hi          = hit_pend_m || hit;
            mi          = miss_pend_m || miss;
            hit_pend_m  = 0;
            miss_pend_m = 0;
            if (hi) exp_hit = (exp_hit + 1) % 100;
            if (mi) begin
                exp_miss    = (exp_miss + 1) % 100;
                flash_on    = 1;
                flash_cnt_m = FLASH_FRAMES - 1;
            end else if (flash_on) begin
                if (flash_cnt_m == 0) flash_on = 0;
                else flash_cnt_m--;
            end
        end else begin
            if (hit) hit_pend_m = 1;
            if (miss) miss_pend_m = 1;
        end
        @(posedge clk_25mhz);
        #1;
        ovl.frame_start = 1'b0;
        ovl.hit_event   = 1'b0;
        ovl.miss_event  = 1'b0;
        ovl.score_clear = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [12:0] exp);
        apply_stimulus(x, y, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output(tag, observed(), exp);
    endtask

    task automatic frame(input bit hit, input bit miss);
        apply_stimulus(0, 0, 1'b0, 1'b1, hit, miss, 1'b0);
    endtask

    task automatic check_digit(input string tag, input int x, input int value,
                               input logic [12:0] colour, input bit shown);
        for (int s = 0; s < 7; s++) begin
            probe($sformatf("%s_seg%0d", tag, s), x + SEG_LX[s], SCORE_Y + SEG_LY[s],
                  (shown && SEG_TAB[value][6-s]) ? colour : OFF);
        end
    endtask

    task automatic check_scores(input string tag);
        check_digit({tag, "_ht"}, HIT_X, exp_hit / 10, WHITE, 1'b1);
        check_digit({tag, "_hu"}, HIT_X + DIGIT_PITCH, exp_hit % 10, WHITE, 1'b1);
        check_digit({tag, "_mt"}, MISS_X, exp_miss / 10, YELLOW, miss_shown());
        check_digit({tag, "_mu"}, MISS_X + DIGIT_PITCH, exp_miss % 10, YELLOW, miss_shown());
    endtask

    initial begin
        ovl.hcount      = 10'd0;
        ovl.vcount      = 10'd0;
        ovl.display_en  = 1'b0;
        ovl.frame_start = 1'b0;
        ovl.hit_event   = 1'b0;
        ovl.miss_event  = 1'b0;
        ovl.score_clear = 1'b0;
        reset           = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_25mhz);
        #1;
        apply_stimulus(HIT_X + 4, SCORE_Y + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("in_reset", observed(), OFF);
        reset = 1'b0;

        frame(1'b0, 1'b0);
        probe("zero_seg_a", HIT_X + 4, SCORE_Y + 1, WHITE);
        probe("zero_seg_g", HIT_X + 4, SCORE_Y + 15, OFF);
        ovl.hcount = 10'(HIT_X + 4);
        ovl.vcount = 10'(SCORE_Y + 1);
        #5;
        check_output("latency_pre", observed(), OFF);
        @(posedge clk_25mhz);
        #1;
        check_output("latency_post", observed(), WHITE);
        apply_stimulus(HIT_X + 4, SCORE_Y + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("blank_no_de", observed(), OFF);
        check_scores("init");

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 0) check_digit("pend_hold", HIT_X + DIGIT_PITCH, 0, WHITE, 1'b1);
            frame(1'b0, 1'b0);
        end
        check_scores("hit12");
        for (int i = 0; i < 87; i++) begin
            apply_stimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            frame(1'b0, 1'b0);
        end
        check_scores("hit99");
        apply_stimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check_scores("hit_wrap");

        frame(1'b1, 1'b1);
        check_scores("same_cycle");
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check_scores("multi_hit");

        for (int i = 0; i < 33; i++) begin
            frame(1'b0, 1'b0);
            probe($sformatf("flash_f%0d", i), MISS_X + 4, SCORE_Y + 1, miss_shown() ? YELLOW : OFF);
        end

        apply_stimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b0);
        check_scores("miss2");
        for (int i = 0; i < 21; i++) begin
            frame(1'b0, 1'b0);
            probe($sformatf("run_f%0d", i), MISS_X + 4, SCORE_Y + 1, miss_shown() ? YELLOW : OFF);
        end
        apply_stimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b0);
        probe("reload", MISS_X + 4, SCORE_Y + 1, miss_shown() ? YELLOW : OFF);
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, 1'b0);
            probe($sformatf("reload_f%0d", i), MISS_X + 4, SCORE_Y + 1, miss_shown() ? YELLOW : OFF);
        end

        apply_stimulus(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_scores("clear");
        frame(1'b0, 1'b0);
        check_scores("clear_pend");

        probe("edge_left", HIT_X - 1, SCORE_Y + 1, OFF);
        probe("edge_right", HIT_X + 16, SCORE_Y + 1, OFF);
        probe("edge_last_col", HIT_X + 15, SCORE_Y + 1, WHITE);
        probe("edge_above", HIT_X + 4, SCORE_Y - 1, OFF);
        probe("edge_last_row", HIT_X + 4, SCORE_Y + 31, WHITE);
        probe("edge_below", HIT_X + 4, SCORE_Y + 32, OFF);

        frame(1'b1, 1'b0);
        probe("pre_reset_px", HIT_X + DIGIT_PITCH + 13, SCORE_Y + 5, WHITE);
        #5;
        reset = 1'b1;
        model_reset();
        #1;
        check_output("async_reset", observed(), OFF);
        #10;
        reset = 1'b0;
        frame(1'b0, 1'b0);
        check_scores("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
